// File: rtl/mmcm_drp_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mmcm_drp_reconfig_ctrl
// Description : Run-time MMCM reconfiguration sequencer. On request it holds
//               the MMCM in reset and performs a masked read-modify-write over
//               the DRP port of every register in the selected configuration.
//               The register tables come from an external synchronous ROM.
//               After the last register it releases the MMCM reset and waits
//               for lock, reporting success or failure with one-cycle pulses.
//
// Optional feature (compile-time macro DRP_VERIFY_EN):
//               When defined, every write is read back and compared. A
//               mismatch aborts the sequence with err_code 3.
//
// Ports       :
//   sys_clk_i      single clock
//   sys_rst_i      synchronous active-high reset
//   cfg_req_i      one-cycle start pulse, honoured only while idle
//   cfg_sel_i      configuration index, captured with cfg_req_i
//   cfg_busy_o     high from the cycle after an accepted request until the
//                  DONE/ERR cycle
//   cfg_done_o     one-cycle success pulse
//   cfg_err_o      one-cycle failure pulse
//   err_code_o     0 none, 1 drdy timeout, 2 lock timeout, 3 verify mismatch;
//                  held until the next accepted request
//   rom_addr_o     {cfg, reg_idx} into the register-table ROM
//   rom_data_i     {daddr[38:32], mask[31:16], data[15:0]}, one cycle latency
//   drp_daddr_o    DRP address
//   drp_di_o       DRP write data
//   drp_den_o      DRP enable strobe
//   drp_dwe_o      DRP write enable
//   drp_do_i       DRP read data
//   drp_drdy_i     DRP ready
//   mmcm_rst_o     MMCM reset
//   mmcm_locked_i  MMCM lock (already synchronous to sys_clk_i)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mmcm_drp_reconfig_ctrl #(
    parameter int NUM_CFG      = 4,
    parameter int REGS_PER_CFG = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 63,
    localparam int CFG_W       = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1,
    localparam int RIDX_W      = (REGS_PER_CFG > 1) ? $clog2(REGS_PER_CFG) : 1
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_i,
    input  logic                    cfg_req_i,
    input  logic [CFG_W-1:0]        cfg_sel_i,
    output logic                    cfg_busy_o,
    output logic                    cfg_done_o,
    output logic                    cfg_err_o,
    output logic [1:0]              err_code_o,
    output logic [CFG_W+RIDX_W-1:0] rom_addr_o,
    input  logic [38:0]             rom_data_i,
    output logic [6:0]              drp_daddr_o,
    output logic [15:0]             drp_di_o,
    output logic                    drp_den_o,
    output logic                    drp_dwe_o,
    input  logic [15:0]             drp_do_i,
    input  logic                    drp_drdy_i,
    output logic                    mmcm_rst_o,
    input  logic                    mmcm_locked_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The shared cycle counter must reach the larger timeout and also the
    // stale-lock blanking threshold.
    localparam int MAX_TO_A = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int MAX_TO   = (MAX_TO_A > 8) ? MAX_TO_A : 8;
    localparam int CNT_W    = $clog2(MAX_TO + 1);

    localparam logic [CNT_W-1:0]  DRDY_LAST   = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    // Lock is ignored for the first 4 LOCK_WAIT cycles: a lock left over from
    // before the reset must not be mistaken for the new lock.
    localparam logic [CNT_W-1:0]  LOCK_IGNORE = CNT_W'(4);
    localparam logic [RIDX_W-1:0] IDX_LAST    = RIDX_W'(REGS_PER_CFG - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_DRDY = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;
`ifdef DRP_VERIFY_EN
    localparam logic [1:0] ERR_VFY  = 2'd3;
`endif

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RST       = 4'd1,
        S_FETCH     = 4'd2,
        S_RD        = 4'd3,
        S_RD_WAIT   = 4'd4,
        S_WR        = 4'd5,
        S_WR_WAIT   = 4'd6,
`ifdef DRP_VERIFY_EN
        S_VFY       = 4'd7,
        S_VFY_WAIT  = 4'd8,
`endif
        S_NEXT      = 4'd9,
        S_LOCK_WAIT = 4'd10,
        S_DONE      = 4'd11,
        S_ERR       = 4'd12
    } state_t;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CFG_W-1:0]          cfg_q;
    logic [RIDX_W-1:0]         idx_q;
    logic [15:0]               mask_q;
    logic [15:0]               data_q;

    logic                      cfg_busy_q;
    logic                      cfg_done_q;
    logic                      cfg_err_q;
    logic [1:0]                err_code_q;
    logic [CFG_W+RIDX_W-1:0]   rom_addr_q;
    logic [6:0]                drp_daddr_q;
    logic [15:0]               drp_di_q;   // also holds wdata for verify
    logic                      drp_den_q;
    logic                      drp_dwe_q;
    logic                      mmcm_rst_q;

    // Merge of the live register value with the table entry: mask bits set
    // keep the value read from the MMCM, cleared bits take the table data.
    logic [15:0]               wdata_d;
    logic [RIDX_W-1:0]         idx_d;

    assign wdata_d = (drp_do_i & mask_q) | (data_q & ~mask_q);
    assign idx_d   = idx_q + 1'b1;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            cfg_busy_q  <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            rom_addr_q  <= '0;
            drp_daddr_q <= '0;
            drp_di_q    <= '0;
            drp_den_q   <= 1'b0;
            drp_dwe_q   <= 1'b0;
            mmcm_rst_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle; the counter runs unless a state
            // transition below clears it.
            drp_den_q  <= 1'b0;
            drp_dwe_q  <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (cfg_req_i) begin
                        cfg_q      <= cfg_sel_i;
                        idx_q      <= '0;
                        err_code_q <= ERR_NONE;
                        cfg_busy_q <= 1'b1;
                        state_q    <= S_RST;
                    end
                end

                S_RST: begin
                    mmcm_rst_q <= 1'b1;
                    rom_addr_q <= {cfg_q, idx_q};
                    cnt_q      <= '0;
                    state_q    <= S_FETCH;
                end

                // First cycle: the ROM sees the new address. Second cycle:
                // its data is valid and is latched while the read is issued.
                S_FETCH: begin
                    if (cnt_q != '0) begin
                        drp_daddr_q <= rom_data_i[38:32];
                        mask_q      <= rom_data_i[31:16];
                        data_q      <= rom_data_i[15:0];
                        drp_den_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_RD;
                    end
                end

                S_RD: begin
                    cnt_q   <= '0;
                    state_q <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (drp_drdy_i) begin
                        drp_di_q  <= wdata_d;
                        drp_den_q <= 1'b1;
                        drp_dwe_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_WR;
                    end else if (cnt_q == DRDY_LAST) begin
                        cfg_err_q  <= 1'b1;
                        err_code_q <= ERR_DRDY;
                        cfg_busy_q <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_ERR;
                    end
                end

                S_WR: begin
                    cnt_q   <= '0;
                    state_q <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (drp_drdy_i) begin
                        cnt_q <= '0;
`ifdef DRP_VERIFY_EN
                        // Read back the same address; daddr is unchanged.
                        drp_den_q <= 1'b1;
                        state_q   <= S_VFY;
`else
                        state_q   <= S_NEXT;
`endif
                    end else if (cnt_q == DRDY_LAST) begin
                        cfg_err_q  <= 1'b1;
                        err_code_q <= ERR_DRDY;
                        cfg_busy_q <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_ERR;
                    end
                end

`ifdef DRP_VERIFY_EN
                S_VFY: begin
                    cnt_q   <= '0;
                    state_q <= S_VFY_WAIT;
                end

                S_VFY_WAIT: begin
                    if (drp_drdy_i) begin
                        cnt_q <= '0;
                        if (drp_do_i != drp_di_q) begin
                            cfg_err_q  <= 1'b1;
                            err_code_q <= ERR_VFY;
                            cfg_busy_q <= 1'b0;
                            mmcm_rst_q <= 1'b0;
                            state_q    <= S_ERR;
                        end else begin
                            state_q    <= S_NEXT;
                        end
                    end else if (cnt_q == DRDY_LAST) begin
                        cfg_err_q  <= 1'b1;
                        err_code_q <= ERR_DRDY;
                        cfg_busy_q <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_ERR;
                    end
                end
`endif

                S_NEXT: begin
                    cnt_q <= '0;
                    if (idx_q == IDX_LAST) begin
                        mmcm_rst_q <= 1'b0;
                        state_q    <= S_LOCK_WAIT;
                    end else begin
                        idx_q      <= idx_d;
                        rom_addr_q <= {cfg_q, idx_d};
                        state_q    <= S_FETCH;
                    end
                end

                S_LOCK_WAIT: begin
                    if ((cnt_q >= LOCK_IGNORE) && mmcm_locked_i) begin
                        cfg_done_q <= 1'b1;
                        cfg_busy_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_DONE;
                    end else if (cnt_q == LOCK_LAST) begin
                        cfg_err_q  <= 1'b1;
                        err_code_q <= ERR_LOCK;
                        cfg_busy_q <= 1'b0;
                        mmcm_rst_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_ERR;
                    end
                end

                S_DONE: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end

                S_ERR: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end

                default: begin
                    cnt_q      <= '0;
                    cfg_busy_q <= 1'b0;
                    mmcm_rst_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cfg_busy_o  = cfg_busy_q;
    assign cfg_done_o  = cfg_done_q;
    assign cfg_err_o   = cfg_err_q;
    assign err_code_o  = err_code_q;
    assign rom_addr_o  = rom_addr_q;
    assign drp_daddr_o = drp_daddr_q;
    assign drp_di_o    = drp_di_q;
    assign drp_den_o   = drp_den_q;
    assign drp_dwe_o   = drp_dwe_q;
    assign mmcm_rst_o  = mmcm_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmcm_drp_reconfig_ctrl
// Description : Directed self-checking bench for mmcm_drp_reconfig_ctrl with
//               behavioural ROM, DRP register file and MMCM lock models.
//               Verify-only scenario is built when DRP_VERIFY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmcm_drp_reconfig_ctrl;

    localparam int c_LOCK_TO = 100;

    logic        r_clk = 1'b0;
    logic        r_sys_rst;
    logic        r_cfg_req;
    logic [1:0]  r_cfg_sel;
    logic [38:0] r_rom_data;
    logic [15:0] r_drp_do;
    logic        r_drp_drdy;
    logic        r_locked;

    logic        w_cfg_busy, w_cfg_done, w_cfg_err;
    logic [1:0]  w_err_code;
    logic [4:0]  w_rom_addr;
    logic [6:0]  w_drp_daddr;
    logic [15:0] w_drp_di;
    logic        w_drp_den, w_drp_dwe, w_mmcm_rst;

    always #5 r_clk = ~r_clk;

    mmcm_drp_reconfig_ctrl #(
        .NUM_CFG      (4),
        .REGS_PER_CFG (8),
        .LOCK_TIMEOUT (c_LOCK_TO),
        .DRDY_TIMEOUT (63)
    ) u_dut (
        .sys_clk_i     (r_clk),
        .sys_rst_i     (r_sys_rst),
        .cfg_req_i     (r_cfg_req),
        .cfg_sel_i     (r_cfg_sel),
        .cfg_busy_o    (w_cfg_busy),
        .cfg_done_o    (w_cfg_done),
        .cfg_err_o     (w_cfg_err),
        .err_code_o    (w_err_code),
        .rom_addr_o    (w_rom_addr),
        .rom_data_i    (r_rom_data),
        .drp_daddr_o   (w_drp_daddr),
        .drp_di_o      (w_drp_di),
        .drp_den_o     (w_drp_den),
        .drp_dwe_o     (w_drp_dwe),
        .drp_do_i      (r_drp_do),
        .drp_drdy_i    (r_drp_drdy),
        .mmcm_rst_o    (w_mmcm_rst),
        .mmcm_locked_i (r_locked)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {28'd0, w_cfg_busy, w_cfg_done, w_cfg_err, w_err_code, w_rom_addr,
                w_drp_daddr, w_drp_di, w_drp_den, w_drp_dwe, w_mmcm_rst};
    endfunction

    // ROM table: cfg 2 entry 0 is {0x08, 0x1000, 0x0145}; cfg 2 uses daddr 8..15.
    function automatic logic [38:0] rom_entry(input logic [4:0] a);
        int c;
        int i;
        logic [6:0]  da;
        logic [15:0] m;
        logic [15:0] d;
        c  = int'(a[4:3]);
        i  = int'(a[2:0]);
        da = 7'(8 + i + 16 * ((c + 2) % 4));
        m  = 16'h1000 | 16'(i * 16'h0011);
        d  = 16'(16'h0145 + i * 16'h0101 + (c ^ 2) * 16'h0300);
        return {da, m, d};
    endfunction

    // ------------------------------------------------------------------------
    // Models (ROM, DRP slave, MMCM lock) and event log, all on negedge
    // ------------------------------------------------------------------------
    logic [15:0] m_regs [0:127];
    logic        m_written [0:127];
    int          m_lat = 1;
    bit          m_no_drdy = 0;
    bit          m_corrupt = 0;
    int          m_cd = 0;
    logic [6:0]  m_p_addr = '0;
    logic        m_p_we = 1'b0;
    logic [15:0] m_p_di = '0;
    logic [4:0]  m_rom_prev = '0;
    int          m_lock_mode = 0;   // 0 delayed lock, 1 stuck 0, 2 stuck 1
    int          m_lock_delay = 20;
    int          m_lock_cnt = 0;
    logic        m_prev_den = 1'b0;
    logic        m_prev_rst = 1'b0;

    int          l_n_rd, l_n_wr, l_n_done, l_n_err;
    int          l_first_den, l_rst_rise, l_rst_fall, l_done_cyc, l_err_cyc;
    int          l_bad_rst, l_b2b, l_bad_cfg;
    logic [15:0] l_first_wdi;
    logic        l_rst_at_err;
    logic [1:0]  l_exp_cfg;
    int          req_cyc;

    task automatic clear_log();
        for (int i = 0; i < 128; i++) begin
            m_regs[i]    = 16'hFFFF;
            m_written[i] = 1'b0;
        end
        m_cd = 0; m_no_drdy = 0; m_corrupt = 0;
        l_n_rd = 0; l_n_wr = 0; l_n_done = 0; l_n_err = 0;
        l_first_den = -1; l_rst_rise = -1; l_rst_fall = -1;
        l_done_cyc = -1; l_err_cyc = -1;
        l_bad_rst = 0; l_b2b = 0; l_bad_cfg = 0;
        l_first_wdi = '0; l_rst_at_err = 1'b1;
    endtask

    initial begin
        r_rom_data = '0;
        r_drp_do   = '0;
        r_drp_drdy = 1'b0;
        r_locked   = 1'b0;
        clear_log();
        forever begin
            @(negedge r_clk);
            // Synchronous ROM: data reflects the address of the previous cycle.
            r_rom_data = rom_entry(m_rom_prev);
            m_rom_prev = w_rom_addr;
            // DRP slave: drdy m_lat cycles after den.
            r_drp_drdy = 1'b0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    r_drp_drdy = 1'b1;
                    if (m_p_we) begin
                        m_regs[m_p_addr]    = m_p_di;
                        m_written[m_p_addr] = 1'b1;
                    end else begin
                        r_drp_do = m_regs[m_p_addr];
                        if (m_corrupt && m_written[m_p_addr] && m_p_addr == 7'd11)
                            r_drp_do[0] = ~r_drp_do[0];
                    end
                end
            end
            if (w_drp_den) begin
                m_p_addr = w_drp_daddr;
                m_p_we   = w_drp_dwe;
                m_p_di   = w_drp_di;
                if (!m_no_drdy) m_cd = m_lat;
                if (w_drp_dwe) begin
                    l_n_wr++;
                    if (l_n_wr == 1) l_first_wdi = w_drp_di;
                end else begin
                    l_n_rd++;
                end
                if (l_first_den < 0) l_first_den = cyc;
                if (!w_mmcm_rst) l_bad_rst++;
                if (w_rom_addr[4:3] != l_exp_cfg) l_bad_cfg++;
            end
            if (w_drp_den && m_prev_den) l_b2b++;
            m_prev_den = w_drp_den;
            // MMCM lock model
            if (w_mmcm_rst) m_lock_cnt = 0;
            else            m_lock_cnt++;
            case (m_lock_mode)
                1:       r_locked = 1'b0;
                2:       r_locked = 1'b1;
                default: r_locked = !w_mmcm_rst && (m_lock_cnt >= m_lock_delay);
            endcase
            if (w_mmcm_rst && !m_prev_rst) l_rst_rise = cyc;
            if (!w_mmcm_rst && m_prev_rst) l_rst_fall = cyc;
            m_prev_rst = w_mmcm_rst;
            if (w_cfg_done) begin l_n_done++; l_done_cyc = cyc; end
            if (w_cfg_err) begin
                l_n_err++;
                l_err_cyc    = cyc;
                l_rst_at_err = w_mmcm_rst;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic start_req(input logic [1:0] sel);
        @(negedge r_clk);
        r_cfg_req = 1'b1;
        r_cfg_sel = sel;
        req_cyc   = cyc;
        @(negedge r_clk);
        r_cfg_req = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int bound);
        int k;
        k = 0;
        while (!(w_cfg_done || w_cfg_err) && k < bound) begin
            @(negedge r_clk);
            k++;
        end
        check_val(tag, 64'(k < bound), 64'd1);
        repeat (3) @(negedge r_clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------------
    initial begin
        int k;
        r_sys_rst = 1'b1;
        r_cfg_req = 1'b0;
        r_cfg_sel = '0;
        l_exp_cfg = 2'd2;
        repeat (3) @(negedge r_clk);
        check_val("reset_outputs", outs_vec(), 64'd0);
        r_sys_rst = 1'b0;
        repeat (2) @(negedge r_clk);

        // Nominal: cfg 2, drdy latency 3, lock 20 cycles after reset release.
        clear_log();
        m_lat = 3; m_lock_mode = 0; m_lock_delay = 20; l_exp_cfg = 2'd2;
        start_req(2'd2);
        check_val("nom_busy_c1", 64'(w_cfg_busy), 64'd1);
        wait_end("nom_end", 2000);
        check_val("nom_rst_rise_cyc", 64'(l_rst_rise - req_cyc), 64'd2);
        check_val("nom_first_den_cyc", 64'(l_first_den - req_cyc), 64'd4);
        check_val("nom_first_wdi", 64'(l_first_wdi), 64'h1145);
`ifdef DRP_VERIFY_EN
        check_val("nom_reads", 64'(l_n_rd), 64'd16);
`else
        check_val("nom_reads", 64'(l_n_rd), 64'd8);
`endif
        check_val("nom_writes", 64'(l_n_wr), 64'd8);
        check_val("nom_rst_during_den", 64'(l_bad_rst), 64'd0);
        check_val("nom_den_b2b", 64'(l_b2b), 64'd0);
        check_val("nom_reg15", 64'(m_regs[15]), 64'h187F);
        check_val("nom_done_after_fall", 64'(l_done_cyc - l_rst_fall), 64'd20);
        check_val("nom_done_cnt", 64'(l_n_done), 64'd1);
        check_val("nom_err_cnt", 64'(l_n_err), 64'd0);
        check_val("nom_err_code", 64'(w_err_code), 64'd0);
        check_val("nom_busy_end", 64'(w_cfg_busy), 64'd0);

        // DRP timeout: no drdy ever.
        clear_log();
        m_no_drdy = 1;
        start_req(2'd2);
        wait_end("drdy_to_end", 300);
        check_val("drdy_to_err_cyc", 64'(l_err_cyc - l_first_den), 64'd64);
        check_val("drdy_to_code", 64'(w_err_code), 64'd1);
        check_val("drdy_to_rst_at_err", 64'(l_rst_at_err), 64'd0);
        check_val("drdy_to_writes", 64'(l_n_wr), 64'd0);
        check_val("drdy_to_err_cnt", 64'(l_n_err), 64'd1);

        // Lock timeout: lock stuck low; the old error code clears on accept.
        clear_log();
        m_lat = 1; m_lock_mode = 1; l_exp_cfg = 2'd0;
        start_req(2'd0);
        check_val("lock_to_code_cleared", 64'(w_err_code), 64'd0);
        wait_end("lock_to_end", 1000);
        check_val("lock_to_code", 64'(w_err_code), 64'd2);
        check_val("lock_to_err_cyc", 64'(l_err_cyc - l_rst_fall), 64'(c_LOCK_TO));
        check_val("lock_to_writes", 64'(l_n_wr), 64'd8);
        check_val("lock_to_cfg", 64'(l_bad_cfg), 64'd0);

        // Stale lock: lock stuck high must be blanked for 4 cycles.
        clear_log();
        m_lat = 1; m_lock_mode = 2; l_exp_cfg = 2'd3;
        start_req(2'd3);
        wait_end("stale_end", 1000);
        check_val("stale_done_after_fall", 64'(l_done_cyc - l_rst_fall), 64'd5);
        check_val("stale_code", 64'(w_err_code), 64'd0);

        // Request while busy is ignored, then reset mid-write.
        clear_log();
        m_lat = 2; m_lock_mode = 0; m_lock_delay = 20; l_exp_cfg = 2'd2;
        start_req(2'd2);
        repeat (8) @(negedge r_clk);
        r_cfg_req = 1'b1;
        r_cfg_sel = 2'd1;
        @(negedge r_clk);
        r_cfg_req = 1'b0;
        k = 0;
        while (!(w_drp_den && w_drp_dwe && l_n_wr >= 2) && k < 500) begin
            @(negedge r_clk);
            k++;
        end
        check_val("busy_req_write_seen", 64'(k < 500), 64'd1);
        check_val("busy_req_cfg", 64'(l_bad_cfg), 64'd0);
        check_val("busy_req_busy", 64'(w_cfg_busy), 64'd1);
        r_sys_rst = 1'b1;
        @(negedge r_clk);
        check_val("midwrite_rst_outputs", outs_vec(), 64'd0);
        r_sys_rst = 1'b0;
        repeat (6) @(negedge r_clk);

`ifdef DRP_VERIFY_EN
        // Verify: readback of reg 3 corrupted in bit 0.
        clear_log();
        m_lat = 1; m_lock_mode = 0; m_corrupt = 1; l_exp_cfg = 2'd2;
        start_req(2'd2);
        wait_end("vfy_end", 1000);
        check_val("vfy_code", 64'(w_err_code), 64'd3);
        check_val("vfy_err_cnt", 64'(l_n_err), 64'd1);
        check_val("vfy_writes", 64'(l_n_wr), 64'd4);
        check_val("vfy_no_reg4_write", 64'(m_written[12]), 64'd0);
        check_val("vfy_rst_at_err", 64'(l_rst_at_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
